trojan_resp_capture: RTL and testbench

Multi-pattern response-capture block for the trojan-detection benchmark flow. It replaces the single-shot "drive constant stimulus, sample one output bit" capture with a sequencer. The sequencer drives an IN_W-bit incrementing stimulus into the DUT for NUM_PAT patterns and waits SETTLE_CYC cycles per pattern. It compacts the OUT_W-bit DUT response into a SIG_W-bit MISR signature, then presents the signature on a valid/ready readout port.

---
 rtl/trojan_cap_pkg.sv | 27 ++
 rtl/trojan_resp_fifo.sv | 56 +++++
 rtl/trojan_resp_capture.sv | 159 +++++++++++++++
 tb/tb_trojan_resp_capture.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_cap_pkg.sv
// Shared types and MISR step for the trojan response-capture sequencer.
package trojan_cap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int unsigned MISR_MAX_W = 64;

  // One MISR step on the low w bits: shift, fold POLY on msb, xor the response in.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] din,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - w);
    nxt  = (sig << 1) & mask;
    if (((sig >> (w - 1)) & MISR_MAX_W'(1)) != '0) nxt = nxt ^ poly;
    return (nxt ^ din) & mask;
  endfunction

endpackage

// File: rtl/trojan_resp_fifo.sv
// Small synchronous FIFO holding raw DUT responses; push when full is dropped unless popping.
module trojan_resp_fifo #(
  parameter  int unsigned W     = 1,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_q];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q] = din;
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    end
    if (rd_en) rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trojan_resp_capture.sv
// Multi-pattern response capture: incrementing stimulus, MISR compaction, valid/ready signature.
// Define RESP_LOG_EN to add the raw-response log FIFO.
module trojan_resp_capture
  import trojan_cap_pkg::*;
#(
  parameter  int unsigned     IN_W       = 3,
  parameter  int unsigned     OUT_W      = 1,
  parameter  int unsigned     SIG_W      = 16,
  parameter  logic [SIG_W-1:0] POLY      = SIG_W'(16'h1021),
  parameter  logic [SIG_W-1:0] SEED      = '0,
  parameter  int unsigned     NUM_PAT    = 8,
  parameter  int unsigned     SETTLE_CYC = 2,
  parameter  int unsigned     LOG_DEPTH  = 4,
  localparam int unsigned     PAT_W      = $clog2(NUM_PAT + 1)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig,
  output logic [PAT_W-1:0] pat_cnt,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [OUT_W-1:0] log_data,
  output logic             log_ovf
);

  localparam int unsigned      CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [PAT_W-1:0] LAST_PAT   = PAT_W'(NUM_PAT - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             sig_valid_q, sig_valid_d;
  logic             sample_c;
  logic             run_start_c;

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    sig_d       = sig_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    sample_c    = 1'b0;
    run_start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          run_start_c = 1'b1;
          state_d     = SETTLE;
          stim_d      = '0;
          sig_d       = SEED;
          pat_d       = '0;
          cnt_d       = CNT_RELOAD;
        end
      end
      SETTLE: begin
        // Last cycle of each pattern: compact the settled response.
        if (cnt_q == '0) begin
          sample_c = 1'b1;
          sig_d    = SIG_W'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(dut_out),
                                      MISR_MAX_W'(POLY), SIG_W));
          pat_d    = pat_q + PAT_W'(1);
          if (pat_q == LAST_PAT) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + IN_W'(1);
            cnt_d  = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == SETTLE);
    sig_valid_d = (state_d == DONE);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stim_q      <= '0;
      sig_q       <= SEED;
      pat_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      sig_q       <= sig_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  assign stim      = stim_q;
  assign sig       = sig_q;
  assign pat_cnt   = pat_q;
  assign busy      = busy_q;
  assign sig_valid = sig_valid_q;

`ifdef RESP_LOG_EN
  logic log_full, log_empty, log_pop;
  logic ovf_q, ovf_d;

  assign log_pop = ~log_empty & log_ready;

  trojan_resp_fifo #(
    .W    (OUT_W),
    .DEPTH(LOG_DEPTH)
  ) u_log_fifo (
    .CK   (CK),
    .reset(reset),
    .push (sample_c),
    .pop  (log_pop),
    .din  (dut_out),
    .dout (log_data),
    .full (log_full),
    .empty(log_empty)
  );

  // Sticky overflow: a sample lost to a full log with no pop in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (run_start_c)                              ovf_d = 1'b0;
    else if (sample_c && log_full && !log_pop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign log_valid = ~log_empty;
  assign log_ovf   = ovf_q;
`else
  logic unused_log;
  assign unused_log = log_ready ^ sample_c ^ run_start_c ^ 1'(LOG_DEPTH);
  assign log_valid  = 1'b0;
  assign log_data   = '0;
  assign log_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_trojan_resp_capture.sv
// Randomized scoreboard bench for trojan_resp_capture; the simulated DUT is a random truth table over stim.
module tb_trojan_resp_capture;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 1;
  localparam int unsigned SIG_W = 8;
  localparam logic [7:0]  POLY  = 8'h1D;
  localparam logic [7:0]  SEED  = 8'h00;
  localparam int          NP_A  = 4;
  localparam int          SC_A  = 2;
  localparam int          NP_B  = 10;
  localparam int          SC_B  = 1;
  localparam int          LD    = 2;

  logic CK = 1'b0;
  logic reset;
  always #5 CK = ~CK;

  logic             start_a, sig_ready_a, log_ready_a;
  logic [IN_W-1:0]  stim_a;
  logic [OUT_W-1:0] dut_out_a;
  logic             busy_a, sig_valid_a, log_valid_a, log_ovf_a;
  logic [SIG_W-1:0] sig_a;
  logic [2:0]       pat_cnt_a;
  logic [OUT_W-1:0] log_data_a;

  logic             start_b, sig_ready_b, log_ready_b;
  logic [IN_W-1:0]  stim_b;
  logic [OUT_W-1:0] dut_out_b;
  logic             busy_b, sig_valid_b, log_valid_b, log_ovf_b;
  logic [SIG_W-1:0] sig_b;
  logic [3:0]       pat_cnt_b;
  logic [OUT_W-1:0] log_data_b;

  logic [7:0] tt_a, tt_b;
  assign dut_out_a = tt_a[stim_a];
  assign dut_out_b = tt_b[stim_b];

  trojan_resp_capture #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED),
    .NUM_PAT(NP_A), .SETTLE_CYC(SC_A), .LOG_DEPTH(LD)
  ) u_dut_a (
    .CK(CK), .reset(reset), .start(start_a), .stim(stim_a), .dut_out(dut_out_a),
    .busy(busy_a), .sig_valid(sig_valid_a), .sig_ready(sig_ready_a), .sig(sig_a),
    .pat_cnt(pat_cnt_a), .log_valid(log_valid_a), .log_ready(log_ready_a),
    .log_data(log_data_a), .log_ovf(log_ovf_a)
  );

  trojan_resp_capture #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED),
    .NUM_PAT(NP_B), .SETTLE_CYC(SC_B), .LOG_DEPTH(LD)
  ) u_dut_b (
    .CK(CK), .reset(reset), .start(start_b), .stim(stim_b), .dut_out(dut_out_b),
    .busy(busy_b), .sig_valid(sig_valid_b), .sig_ready(sig_ready_b), .sig(sig_b),
    .pat_cnt(pat_cnt_b), .log_valid(log_valid_b), .log_ready(log_ready_b),
    .log_data(log_data_b), .log_ovf(log_ovf_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic over integers: double, reduce past 8 bits, add response.
  function automatic logic [7:0] ref_sig(input int np, input logic [7:0] tt);
    int s;
    s = int'(SEED);
    for (int p = 0; p < np; p++) begin
      s = s * 2;
      if (s > 255) s = (s - 256) ^ int'(POLY);
      s = s ^ int'(tt[3'(p % 8)]);
    end
    return 8'(s);
  endfunction

  typedef struct packed {
    logic [7:0] sig;
    logic [2:0] pat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   busy_n;
  bit   prev_v;

  // Monitor: stim sequence during the run, signature on valid rise, stability while held.
  always @(negedge CK) begin
    if (reset) begin
      busy_n = 0;
      prev_v = 1'b0;
    end else begin
      if (busy_a) begin
        chk("stim_a", 32'(stim_a), 32'((busy_n / SC_A) % 8));
        busy_n++;
      end
      if (sig_valid_a && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(sig_valid_a), 32'(0));
        end else begin
          cur = exp_q.pop_front();
          chk("sig_a", 32'(sig_a), 32'(cur.sig));
          chk("pat_cnt_a", 32'(pat_cnt_a), 32'(cur.pat));
          chk("run_len_a", 32'(busy_n), 32'(NP_A * SC_A));
        end
      end else if (sig_valid_a) begin
        chk("sig_hold_a", 32'(sig_a), 32'(cur.sig));
        chk("pat_hold_a", 32'(pat_cnt_a), 32'(cur.pat));
      end
      if (!busy_a && !sig_valid_a) busy_n = 0;
      prev_v = sig_valid_a;
`ifndef RESP_LOG_EN
      chk("log_tied", 32'({log_valid_a, log_ovf_a, log_data_a}), 32'(0));
`endif
    end
  end

  task automatic check_reset_a;
    chk("rst_stim", 32'(stim_a), 32'(0));
    chk("rst_sig", 32'(sig_a), 32'(SEED));
    chk("rst_pat", 32'(pat_cnt_a), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_valid", 32'(sig_valid_a), 32'(0));
    chk("rst_log", 32'({log_valid_a, log_ovf_a, log_data_a}), 32'(0));
  endtask

  task automatic wait_valid_a;
    int i;
    i = 0;
    while (!sig_valid_a && i < 200) begin
      @(negedge CK);
      i++;
    end
    if (!sig_valid_a) chk("valid_timeout_a", 32'(sig_valid_a), 32'(1));
  endtask

  task automatic run_a(input logic [7:0] tt, input int hold, input bit start_in_hold);
    logic [7:0] e;
    e    = ref_sig(NP_A, tt);
    tt_a = tt;
    start_a = 1'b1;
    exp_q.push_back('{sig: e, pat: 3'(NP_A)});
    @(negedge CK);
    start_a = 1'b0;
    wait_valid_a;
    for (int i = 0; i < hold; i++) begin
      start_a = start_in_hold && (i == hold / 2);
      @(negedge CK);
    end
    start_a     = start_in_hold;
    sig_ready_a = 1'b1;
    @(negedge CK);
    sig_ready_a = 1'b0;
    start_a     = 1'b0;
    chk("valid_drop", 32'(sig_valid_a), 32'(0));
    chk("idle_busy", 32'(busy_a), 32'(0));
    @(negedge CK);
    chk("no_rerun", 32'(busy_a), 32'(0));
    chk("sig_keep", 32'(sig_a), 32'(e));
    chk("pat_keep", 32'(pat_cnt_a), 32'(NP_A));
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; sig_ready_a = 1'b0; log_ready_a = 1'b1;
    start_b = 1'b0; sig_ready_b = 1'b0; log_ready_b = 1'b1;
    tt_a = 8'h00; tt_b = 8'h00;
    repeat (2) @(negedge CK);
    check_reset_a;
    chk("rst_sig_b", 32'(sig_b), 32'(SEED));
    chk("rst_pat_b", 32'(pat_cnt_b), 32'(0));
    reset = 1'b0;
    @(negedge CK);

    // Constant-1 and constant-0 responses, the latter with a held readout and stray starts.
    run_a(8'hFF, 0, 1'b0);
    chk("plan1_sig", 32'(sig_a), 32'(8'h0F));
    run_a(8'h00, 5, 1'b1);
    chk("plan2_sig", 32'(sig_a), 32'(8'h00));

    // Reset during the third pattern, then a clean rerun.
    tt_a = 8'hFF;
    start_a = 1'b1;
    exp_q.push_back('{sig: ref_sig(NP_A, 8'hFF), pat: 3'(NP_A)});
    @(negedge CK);
    start_a = 1'b0;
    repeat (4) @(negedge CK);
    chk("mid_run_busy", 32'(busy_a), 32'(1));
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check_reset_a;
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    run_a(8'hFF, 0, 1'b0);
    chk("post_reset_sig", 32'(sig_a), 32'(8'h0F));

    // Ten single-cycle patterns: stim wraps through 0..7,0,1.
    tt_b = 8'($urandom);
    start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    for (int k = 0; k < NP_B; k++) begin
      chk("busy_b", 32'(busy_b), 32'(1));
      chk("stim_b", 32'(stim_b), 32'(k % 8));
      @(negedge CK);
    end
    chk("valid_b", 32'(sig_valid_b), 32'(1));
    chk("sig_b", 32'(sig_b), 32'(ref_sig(NP_B, tt_b)));
    chk("pat_cnt_b", 32'(pat_cnt_b), 32'(NP_B));
    sig_ready_b = 1'b1;
    @(negedge CK);
    sig_ready_b = 1'b0;
    chk("valid_drop_b", 32'(sig_valid_b), 32'(0));

    for (int r = 0; r < 6; r++) begin
      run_a(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CK);
    end

`ifdef RESP_LOG_EN
    begin
      logic [7:0] tl;
      tl = 8'($urandom);
      log_ready_a = 1'b0;
      run_a(tl, 0, 1'b0);
      chk("log_valid", 32'(log_valid_a), 32'(1));
      chk("log_ovf", 32'(log_ovf_a), 32'(1));
      chk("log_head0", 32'(log_data_a), 32'(tl[0]));
      log_ready_a = 1'b1;
      @(negedge CK);
      chk("log_head1", 32'(log_data_a), 32'(tl[1]));
      chk("log_valid1", 32'(log_valid_a), 32'(1));
      @(negedge CK);
      chk("log_empty", 32'(log_valid_a), 32'(0));
      run_a(8'($urandom), 0, 1'b0);
      chk("log_ovf_clr", 32'(log_ovf_a), 32'(0));
    end
`endif

    repeat (2) @(negedge CK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
